// File: rtl/fir_seq_fsm.sv
// fir_seq_fsm -- sequencer for a time-multiplexed FIR filter.
//
// One incoming sample starts a frame: STORE writes the sample into the
// circular delay line and clears the accumulator, MAC walks all N_TAPS
// taps, SAVE copies the accumulator to the result register and advances
// the write pointer, and OUT presents the result.
//
// All outputs are registered: they are decoded from the next state, so they
// line up with the state the FSM is actually in during each cycle.
//
// Optional feature: define FIR_SEQ_HANDSHAKE_EN to hold OUT until out_ready
// is high. Without it, out_ready is ignored and OUT lasts one cycle.

module fir_seq_fsm #(
   parameter int N_TAPS = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk_b,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic              out_ready,
   output logic              FSM_reset_Acc,
   output logic              FSM_Acc_en,
   output logic              FSM_Acc_zapis,
   output logic              sample_wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] tap_addr,
   output logic              wynik_valid,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STORE = 3'd1,
      MAC   = 3'd2,
      SAVE  = 3'd3,
      OUT   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);
   localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
   localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N_TAPS);

   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] tap_r;
   logic [ADDR_W-1:0] tap_s;
   logic [ADDR_W-1:0] wr_r;
   logic [ADDR_W-1:0] wr_s;

   logic              reset_acc_s;
   logic              acc_en_s;
   logic              acc_zapis_s;
   logic              wr_en_s;
   logic              wynik_s;
   logic              busy_s;
   logic [ADDR_W-1:0] rd_s;
   logic [ADDR_W-1:0] tap_out_s;

   // Ring subtraction (a - b) mod N_TAPS; exact for non-power-of-2 N_TAPS.
   function automatic logic [ADDR_W-1:0] ring_sub(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
      logic [ADDR_W:0] sum;
      sum = {1'b0, a} + N_EXT - {1'b0, b};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end else begin
         sum = sum;
      end
      return sum[ADDR_W-1:0];
   endfunction

   // Ring increment, wrapping N_TAPS-1 back to 0.
   function automatic logic [ADDR_W-1:0] ring_inc(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      if (a == LAST_TAP) begin
         r = ZERO_A;
      end else begin
         r = a + ADDR_W'(1);
      end
      return r;
   endfunction

`ifndef FIR_SEQ_HANDSHAKE_EN
   // out_ready has no function in the single-cycle OUT build.
   logic unused_ready_s;
   assign unused_ready_s = out_ready;
`endif

   // State, tap counter and write pointer registers.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         tap_r   <= ZERO_A;
         wr_r    <= ZERO_A;
      end else begin
         state_r <= state_s;
         tap_r   <= tap_s;
         wr_r    <= wr_s;
      end
   end

   // Next-state, tap counter and write pointer decode.
   always_comb begin
      state_s = state_r;
      tap_s   = tap_r;
      wr_s    = wr_r;
      case (state_r)
         IDLE: begin
            if (sample_valid) begin
               state_s = STORE;
               tap_s   = ZERO_A;
            end else begin
               state_s = IDLE;
            end
         end
         STORE: begin
            state_s = MAC;
            tap_s   = ZERO_A;
         end
         MAC: begin
            if (tap_r == LAST_TAP) begin
               state_s = SAVE;
               tap_s   = ZERO_A;
            end else begin
               state_s = MAC;
               tap_s   = tap_r + ADDR_W'(1);
            end
         end
         SAVE: begin
            state_s = OUT;
            wr_s    = ring_inc(wr_r);
         end
         OUT: begin
`ifdef FIR_SEQ_HANDSHAKE_EN
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
`else
            state_s = IDLE;
`endif
         end
         default: begin
            state_s = IDLE;
            tap_s   = ZERO_A;
         end
      endcase
   end

   // Output decode from the next state so registered outputs match the state.
   always_comb begin
      reset_acc_s = 1'b0;
      acc_en_s    = 1'b0;
      acc_zapis_s = 1'b0;
      wr_en_s     = 1'b0;
      wynik_s     = 1'b0;
      busy_s      = 1'b1;
      rd_s        = ZERO_A;
      tap_out_s   = ZERO_A;
      case (state_s)
         IDLE: begin
            busy_s = 1'b0;
         end
         STORE: begin
            reset_acc_s = 1'b1;
            wr_en_s     = 1'b1;
         end
         MAC: begin
            acc_en_s  = 1'b1;
            tap_out_s = tap_s;
            rd_s      = ring_sub(wr_s, tap_s);
         end
         SAVE: begin
            acc_zapis_s = 1'b1;
         end
         OUT: begin
            wynik_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Registered strobes and addresses.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         FSM_reset_Acc <= 1'b0;
         FSM_Acc_en    <= 1'b0;
         FSM_Acc_zapis <= 1'b0;
         sample_wr_en  <= 1'b0;
         wynik_valid   <= 1'b0;
         busy          <= 1'b0;
         rd_addr       <= ZERO_A;
         tap_addr      <= ZERO_A;
         wr_addr       <= ZERO_A;
      end else begin
         FSM_reset_Acc <= reset_acc_s;
         FSM_Acc_en    <= acc_en_s;
         FSM_Acc_zapis <= acc_zapis_s;
         sample_wr_en  <= wr_en_s;
         wynik_valid   <= wynik_s;
         busy          <= busy_s;
         rd_addr       <= rd_s;
         tap_addr      <= tap_out_s;
         wr_addr       <= wr_s;
      end
   end

   // Sticky overrun: a sample offered while a frame is in flight is dropped.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else begin
         overrun <= overrun | (sample_valid & busy);
      end
   end

endmodule

// File: tb/tb_fir_seq_fsm.sv
// tb_fir_seq_fsm -- directed plus randomized checks of fir_seq_fsm.
// Two instances: N_TAPS=4 (power of two) and N_TAPS=5 (exercises the
// modulo wrap of rd_addr). Each frame's expected trace is derived from the
// frame rules: STORE, N_TAPS MAC cycles with rd=(p-k) mod N, SAVE, OUT.

module tb_fir_seq_fsm;

   logic clk_b = 1'b0;
   always #5 clk_b = ~clk_b;

   logic rst_n;
   logic sv4;
   logic sv5;
   logic out_ready;

   logic       a_ra, a_en, a_zp, a_we, a_wv, a_bs, a_ov;
   logic [1:0] a_wa, a_rd, a_ta;
   logic       b_ra, b_en, b_zp, b_we, b_wv, b_bs, b_ov;
   logic [2:0] b_wa, b_rd, b_ta;

   fir_seq_fsm #(.N_TAPS(4), .ADDR_W(2)) dut4 (
      .clk_b(clk_b), .rst_n(rst_n), .sample_valid(sv4), .out_ready(out_ready),
      .FSM_reset_Acc(a_ra), .FSM_Acc_en(a_en), .FSM_Acc_zapis(a_zp),
      .sample_wr_en(a_we), .wr_addr(a_wa), .rd_addr(a_rd), .tap_addr(a_ta),
      .wynik_valid(a_wv), .busy(a_bs), .overrun(a_ov)
   );

   fir_seq_fsm #(.N_TAPS(5), .ADDR_W(3)) dut5 (
      .clk_b(clk_b), .rst_n(rst_n), .sample_valid(sv5), .out_ready(out_ready),
      .FSM_reset_Acc(b_ra), .FSM_Acc_en(b_en), .FSM_Acc_zapis(b_zp),
      .sample_wr_en(b_we), .wr_addr(b_wa), .rd_addr(b_rd), .tap_addr(b_ta),
      .wynik_valid(b_wv), .busy(b_bs), .overrun(b_ov)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;
   int ptr [2];
   bit ovr [2];
   int ntaps [2];
   bit pend = 1'b0;

   // Strobe exclusivity and no accumulator clear while a result is shown.
   always @(negedge clk_b) begin
      n_tests++;
      assert ($onehot0({a_ra, a_en, a_zp}) && !(a_ra && a_wv) &&
              $onehot0({b_ra, b_en, b_zp}) && !(b_ra && b_wv))
      else begin
         n_fail++;
         $error("FAIL excl observed=%b%b%b/%b%b%b expected=at most one high",
                a_ra, a_en, a_zp, b_ra, b_en, b_zp);
      end
   end

   function automatic logic [30:0] pack(bit ra, bit en, bit zp, bit we, bit wv,
                                        bit bs, bit ov, int wa, int rd, int ta);
      return {ra, en, zp, we, wv, bs, ov, 8'(wa), 8'(rd), 8'(ta)};
   endfunction

   function automatic logic [30:0] observed();
      logic [30:0] o;
      if (sel == 0)
         o = {a_ra, a_en, a_zp, a_we, a_wv, a_bs, a_ov,
              8'(a_wa), 8'(a_rd), 8'(a_ta)};
      else
         o = {b_ra, b_en, b_zp, b_we, b_wv, b_bs, b_ov,
              8'(b_wa), 8'(b_rd), 8'(b_ta)};
      return o;
   endfunction

   task automatic check(input string tag, input logic [30:0] exp);
      logic [30:0] o;
      o = observed();
      n_tests++;
      assert (o === exp)
      else begin
         n_fail++;
         $error("FAIL %s n=%0d observed=%08h expected=%08h", tag, ntaps[sel], o, exp);
      end
   endtask

   task automatic drive_sv(input bit v);
      if (sel == 0) sv4 = v;
      else          sv5 = v;
   endtask

   // One clock; retires a pending overrun strobe.
   task automatic advance();
      @(posedge clk_b);
      #1;
      if (pend) begin
         drive_sv(1'b0);
         ovr[sel] = 1'b1;
         pend     = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, pack(0, 0, 0, 0, 0, 0, ovr[sel], ptr[sel], 0, 0));
   endtask

   // Launch one frame and check every cycle of it.
   task automatic frame(input int intrude_at, input int abort_at, input int hs_delay);
      int n;
      int p;
      n = ntaps[sel];
      p = ptr[sel];
      drive_sv(1'b1);
      advance();
      drive_sv(1'b0);
      check("store", pack(1, 0, 0, 1, 0, 1, ovr[sel], p, 0, 0));
      for (int k = 0; k < n; k++) begin
         advance();
         check("mac", pack(0, 1, 0, 0, 0, 1, ovr[sel], p, (p - k + n) % n, k));
         if (k == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            ptr = '{0, 0};
            ovr = '{1'b0, 1'b0};
            check("abort", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            advance();
            check("abort_hold", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            rst_n = 1'b1;
            advance();
            check_idle("post_abort");
            return;
         end
         if (k == intrude_at) begin
            drive_sv(1'b1);
            pend = 1'b1;
         end
      end
      advance();
      check("save", pack(0, 0, 1, 0, 0, 1, ovr[sel], p, 0, 0));
      ptr[sel] = (p + 1) % n;
      advance();
      check("out", pack(0, 0, 0, 0, 1, 1, ovr[sel], ptr[sel], 0, 0));
`ifdef FIR_SEQ_HANDSHAKE_EN
      for (int i = 0; i < hs_delay; i++) begin
         out_ready = 1'b0;
         advance();
         check("out_hold", pack(0, 0, 0, 0, 1, 1, ovr[sel], ptr[sel], 0, 0));
      end
      out_ready = 1'b1;
`else
      if (hs_delay >= 0) out_ready = 1'($urandom_range(0, 1));
`endif
      advance();
      check_idle("idle_after");
   endtask

   initial begin
      int gap;
      int intr;
      ntaps     = '{4, 5};
      ptr       = '{0, 0};
      ovr       = '{1'b0, 1'b0};
      rst_n     = 1'b0;
      sv4       = 1'b0;
      sv5       = 1'b0;
      out_ready = 1'b1;
      advance();
      advance();
      sel = 0; check_idle("reset4");
      sel = 1; check_idle("reset5");
      rst_n = 1'b1;
      sel = 0;
      for (int i = 0; i < 3; i++) begin
         advance();
         check_idle("idle_gap");
      end

      // Single frame, then four more back-to-back: wr_addr 0,1,2,3,0.
      for (int f = 0; f < 5; f++) frame(-1, -1, 0);

      // Non-power-of-2 ring on the 5-tap instance.
      sel = 1;
      for (int f = 0; f < 6; f++) frame(-1, -1, 0);

      // Randomized frames with gaps and occasional intruding samples.
      for (int f = 0; f < 24; f++) begin
         sel = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            advance();
            check_idle("rand_gap");
         end
         if ($urandom_range(0, 3) == 0) intr = int'($urandom_range(0, ntaps[sel] - 1));
         else                           intr = -1;
         frame(intr, -1, int'($urandom_range(0, 3)));
      end

      // Directed overrun during MAC, then confirm it stays set.
      sel = 0;
      frame(1, -1, 0);
      frame(-1, -1, 0);

      // Reset at MAC tap 2 abandons the frame; next sample lands at 0.
      frame(-1, 2, 0);
      frame(-1, -1, 0);
      sel = 1;
      frame(-1, -1, 0);

`ifdef FIR_SEQ_HANDSHAKE_EN
      sel = 0;
      frame(-1, -1, 5);
`endif

      advance();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
